// File: rtl/servant_ram_arbiter.sv
// Round-robin Wishbone arbiter that shares the single-port servant RAM between
// the read-only instruction bus and the read/write data bus.
module servant_ram_arbiter #(
    parameter int aw         = 10,
    parameter bit IBUS_FIRST = 1'b1
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic [aw-1:2] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [aw-1:2] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [aw-1:2] o_ram_adr,
    output logic [31:0]   o_ram_dat,
    output logic [3:0]    o_ram_sel,
    output logic          o_ram_we,
    output logic          o_ram_cyc,
    input  logic [31:0]   i_ram_rdt,
    input  logic          i_ram_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_i;

    function automatic state_t next_grant(input logic ireq, input logic dreq, input logic prev_i);
        state_t g;
        g = IDLE;
        if (ireq && dreq)
            g = prev_i ? GNT_D : GNT_I;
        else if (ireq)
            g = GNT_I;
        else if (dreq)
            g = GNT_D;
        return g;
    endfunction

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state  <= IDLE;
            last_i <= !IBUS_FIRST;
        end else begin
            state <= state_nxt;
            if (state_nxt == GNT_I)
                last_i <= 1'b1;
            else if (state_nxt == GNT_D)
                last_i <= 1'b0;
        end
    end

    // Outputs decode only the state register, so no request input reaches o_ram_cyc.
    always_comb begin
        state_nxt  = state;
        o_ram_cyc  = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_adr  = i_dbus_adr;
        o_ram_dat  = i_dbus_dat;
        o_ram_sel  = i_dbus_sel;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = next_grant(i_ibus_cyc, i_dbus_cyc, last_i);
            end
            GNT_I: begin
                o_ram_cyc  = 1'b1;
                o_ram_adr  = i_ibus_adr;
                o_ram_dat  = 32'd0;
                o_ram_sel  = 4'hF;
                o_ibus_ack = i_ram_ack & i_ibus_cyc;
                // Mask the finishing master so the other one can follow without an idle cycle.
                if (i_ram_ack)
                    state_nxt = next_grant(1'b0, i_dbus_cyc, last_i);
            end
            GNT_D: begin
                o_ram_cyc  = 1'b1;
                o_ram_we   = i_dbus_we;
                o_dbus_ack = i_ram_ack & i_dbus_cyc;
                if (i_ram_ack)
                    state_nxt = next_grant(i_ibus_cyc, 1'b0, last_i);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_ibus_rdt = i_ram_rdt;
    assign o_dbus_rdt = i_ram_rdt;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Randomised scoreboard bench for servant_ram_arbiter with a behavioural servant
// RAM, a transaction-level memory model and directed arbitration scenarios.
module tb_servant_ram_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:2] ibus_adr;
    logic          ibus_cyc;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic [AW-1:2] dbus_adr;
    logic [31:0]   dbus_dat;
    logic [3:0]    dbus_sel;
    logic          dbus_we;
    logic          dbus_cyc;
    logic [31:0]   dbus_rdt;
    logic          dbus_ack;
    logic [AW-1:2] ram_adr;
    logic [31:0]   ram_dat;
    logic [3:0]    ram_sel;
    logic          ram_we;
    logic          ram_cyc;
    logic [31:0]   ram_rdt;
    logic          ram_ack;
    logic          ram_ack_q;
    logic          force_ack;

    // Second instance only observes which master wins first with IBUS_FIRST=0.
    logic [AW-1:2] ram0_adr;
    logic [31:0]   ram0_dat;
    logic [3:0]    ram0_sel;
    logic          ram0_we;
    logic          ram0_cyc;
    logic          ram0_ack_q;
    logic [31:0]   ibus0_rdt;
    logic          ibus0_ack;
    logic [31:0]   dbus0_rdt;
    logic          dbus0_ack;

    logic [31:0] ram_mem [0:255];
    logic [31:0] ref_mem [0:255];

    logic [31:0] ibq[$];
    logic [31:0] dbq_d[$];
    logic        dbq_we[$];
    int          ack_who_q[$];
    int          ack_cyc_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    logic        mon_we;
    logic [31:0] mon_d;

    always #5 clk = ~clk;

    assign ram_ack = ram_ack_q | force_ack;

    servant_ram_arbiter #(.aw(AW), .IBUS_FIRST(1'b1)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
        .o_ram_adr(ram_adr), .o_ram_dat(ram_dat), .o_ram_sel(ram_sel), .o_ram_we(ram_we),
        .o_ram_cyc(ram_cyc), .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack)
    );

    servant_ram_arbiter #(.aw(AW), .IBUS_FIRST(1'b0)) dut0 (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus0_rdt), .o_ibus_ack(ibus0_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus0_rdt), .o_dbus_ack(dbus0_ack),
        .o_ram_adr(ram0_adr), .o_ram_dat(ram0_dat), .o_ram_sel(ram0_sel), .o_ram_we(ram0_we),
        .o_ram_cyc(ram0_cyc), .i_ram_rdt(32'd0), .i_ram_ack(ram0_ack_q)
    );

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Servant RAM: ack one cycle after cyc, never two cycles in a row.
    always @(posedge clk) begin
        ram_ack_q  <= rst ? 1'b0 : (ram_cyc & ~ram_ack_q);
        ram0_ack_q <= rst ? 1'b0 : (ram0_cyc & ~ram0_ack_q);
        if (ram_cyc && !ram_ack_q) begin
            ram_rdt <= ram_mem[ram_adr];
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) ram_mem[ram_adr][8*b +: 8] <= ram_dat[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h cycle=%0d", nm, act, exp, cyc_n);
        end
    endtask

    // Monitor: every master ack pops the scoreboard entry queued at issue time.
    always @(negedge clk) begin
        if (!rst && (ibus_ack || dbus_ack)) begin
            chk("ack_exclusive", 32'(ibus_ack & dbus_ack), 32'd0);
            if (ibus_ack) begin
                ack_who_q.push_back(0);
                ack_cyc_q.push_back(cyc_n);
                if (ibq.size() == 0)
                    chk("ibus_unexpected_ack", 32'(ibus_ack), 32'd0);
                else
                    chk("ibus_rdt", ibus_rdt, ibq.pop_front());
            end
            if (dbus_ack) begin
                ack_who_q.push_back(1);
                ack_cyc_q.push_back(cyc_n);
                if (dbq_we.size() == 0)
                    chk("dbus_unexpected_ack", 32'(dbus_ack), 32'd0);
                else begin
                    mon_we = dbq_we.pop_front();
                    mon_d  = dbq_d.pop_front();
                    if (mon_we)
                        chk("dbus_wr_we", 32'(ram_we), 32'd1);
                    else
                        chk("dbus_rdt", dbus_rdt, mon_d);
                end
            end
        end
    end

    task automatic ibus_rd(input logic [AW-1:2] a);
        int n;
        ibus_adr = a;
        ibus_cyc = 1'b1;
        ibq.push_back(ref_mem[a]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ibus_ack && n < 40);
        if (!ibus_ack) chk("ibus_ack_timeout", 32'(ibus_ack), 32'd1);
        @(posedge clk); #1;
        ibus_cyc = 1'b0;
    endtask

    task automatic dbus_tx(input logic we, input logic [AW-1:2] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd);
        int n;
        dbus_adr = a;
        dbus_dat = d;
        dbus_sel = s;
        dbus_we  = we;
        dbus_cyc = 1'b1;
        if (we)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        dbq_we.push_back(we);
        dbq_d.push_back(exp_rd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dbus_ack && n < 40);
        if (!dbus_ack) chk("dbus_ack_timeout", 32'(dbus_ack), 32'd1);
        @(posedge clk); #1;
        dbus_cyc = 1'b0;
        dbus_we  = 1'b0;
    endtask

    task automatic dbus_rd(input logic [AW-1:2] a);
        dbus_tx(1'b0, a, $urandom, 4'($urandom), ref_mem[a]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [31:0] v;
        rst = 1'b1; force_ack = 1'b1;
        ibus_adr = '0; ibus_cyc = 1'b1;
        dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b1; dbus_cyc = 1'b1;

        // Reset holds everything quiet even with requests and a RAM ack present.
        repeat (3) @(negedge clk);
        chk("rst_ram_cyc", 32'(ram_cyc), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ibus_ack", 32'(ibus_ack), 32'd0);
        chk("rst_dbus_ack", 32'(dbus_ack), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0; ibus_cyc = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
        rst = 1'b0;

        for (int a = 0; a < 64; a++) begin
            v = (a == 16) ? 32'hDEADBEEF : (a == 4) ? 32'h0 : $urandom;
            dbus_tx(1'b1, 8'(a), v, 4'hF, 32'h0);
        end

        // Single ibus read with exact latency.
        fork
            ibus_rd(8'h10);
            begin
                @(negedge clk);
                chk("iread_cyc0_ram_cyc", 32'(ram_cyc), 32'd0);
                @(negedge clk);
                chk("iread_cyc1_ram_cyc", 32'(ram_cyc), 32'd1);
                chk("iread_ram_we", 32'(ram_we), 32'd0);
                chk("iread_ram_sel", 32'(ram_sel), 32'hF);
                chk("iread_ram_adr", 32'(ram_adr), 32'h10);
                chk("iread_ram_dat", ram_dat, 32'h0);
                @(negedge clk);
                chk("iread_cyc2_ack", 32'(ibus_ack), 32'd1);
                chk("iread_cyc2_rdt", ibus_rdt, 32'hDEADBEEF);
            end
        join

        // Byte write over zero, then readback.
        fork
            dbus_tx(1'b1, 8'h04, 32'h11223344, 4'b0010, 32'h0);
            begin
                @(negedge clk);
                chk("dwr_idle_we", 32'(ram_we), 32'd0);
                @(negedge clk);
                chk("dwr_gnt_we", 32'(ram_we), 32'd1);
                chk("dwr_gnt_sel", 32'(ram_sel), 32'h2);
                chk("dwr_gnt_dat", ram_dat, 32'h11223344);
                chk("dwr_gnt_adr", 32'(ram_adr), 32'h4);
                @(negedge clk);
                chk("dwr_cyc2_ack", 32'(dbus_ack), 32'd1);
            end
        join
        dbus_tx(1'b0, 8'h04, 32'hFFFFFFFF, 4'hF, 32'h00003300);

        // sel=0 write leaves the word unchanged.
        dbus_tx(1'b1, 8'd20, 32'hA5A5A5A5, 4'h0, 32'h0);
        dbus_rd(8'd20);

        // Both masters requesting continuously straight out of reset.
        do_reset();
        ack_who_q.delete(); ack_cyc_q.delete();
        c0 = cyc_n;
        fork
            begin ibus_rd(8'd1); ibus_rd(8'd2); ibus_rd(8'd3); end
            begin dbus_rd(8'd40); dbus_rd(8'd41); dbus_rd(8'd42); end
            begin
                @(negedge clk); @(negedge clk);
                chk("first_grant_ibus_first", 32'(ram_adr), 32'd1);
                chk("first_grant_dbus_first", 32'(ram0_adr), 32'd40);
            end
        join
        chk("alt_count", 32'(ack_cyc_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < ack_cyc_q.size(); k++) begin
            chk($sformatf("alt_who%0d", k), 32'(ack_who_q[k]), 32'(k % 2));
            chk($sformatf("alt_cyc%0d", k), 32'(ack_cyc_q[k]), 32'(c0 + 2 + 2 * k));
        end

        // dbus arrives mid ibus transaction and is granted right after the ibus ack.
        ack_who_q.delete(); ack_cyc_q.delete();
        c0 = cyc_n;
        fork
            ibus_rd(8'd5);
            begin @(posedge clk); #1; dbus_rd(8'd50); end
            begin
                repeat (4) @(negedge clk);
                chk("b2b_ram_cyc", 32'(ram_cyc), 32'd1);
                chk("b2b_ram_adr", 32'(ram_adr), 32'd50);
            end
        join
        chk("b2b_count", 32'(ack_cyc_q.size()), 32'd2);
        if (ack_cyc_q.size() == 2) begin
            chk("b2b_i_cyc", 32'(ack_cyc_q[0]), 32'(c0 + 2));
            chk("b2b_d_cyc", 32'(ack_cyc_q[1]), 32'(c0 + 4));
        end

        // ibus abandons its request while granted: grant held, ack swallowed.
        ack_who_q.delete(); ack_cyc_q.delete();
        ibus_adr = 8'd7; ibus_cyc = 1'b1;
        @(posedge clk); #1;
        ibus_cyc = 1'b0;
        @(negedge clk);
        chk("abuse_c1_ram_cyc", 32'(ram_cyc), 32'd1);
        @(negedge clk);
        chk("abuse_c2_ram_cyc", 32'(ram_cyc), 32'd1);
        chk("abuse_c2_ibus_ack", 32'(ibus_ack), 32'd0);
        @(negedge clk);
        chk("abuse_c3_idle", 32'(ram_cyc), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("spur_idle_ibus_ack", 32'(ibus_ack), 32'd0);
        chk("spur_idle_dbus_ack", 32'(dbus_ack), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("spur_idle_stays", 32'(ram_cyc), 32'd0);
        chk("abuse_no_acks", 32'(ack_cyc_q.size()), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b1;
        fork
            ibus_rd(8'd8);
            begin @(posedge clk); #1; force_ack = 1'b0; end
        join

        // Asynchronous reset in the middle of a dbus transaction.
        ack_who_q.delete(); ack_cyc_q.delete();
        dbus_adr = 8'd9; dbus_we = 1'b0; dbus_cyc = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_pre_ram_cyc", 32'(ram_cyc), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_async_ram_cyc", 32'(ram_cyc), 32'd0);
        dbus_cyc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk("rstmid_c1_ibus_ack", 32'(ibus_ack), 32'd0);
        chk("rstmid_c1_dbus_ack", 32'(dbus_ack), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_ibus_ack", 32'(ibus_ack), 32'd0);
            chk("rstmid_dbus_ack", 32'(dbus_ack), 32'd0);
        end
        @(posedge clk); #1;
        chk("rstmid_no_acks", 32'(ack_cyc_q.size()), 32'd0);
        fork
            dbus_rd(8'd9);
            begin
                repeat (3) @(negedge clk);
                chk("rstmid_after_ack", 32'(dbus_ack), 32'd1);
            end
        join

        // Random concurrent traffic; ibus reads a region dbus never writes here.
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                ibus_rd(8'($urandom_range(0, 15)));
            end
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 1) == 1)
                    dbus_tx(1'b1, 8'($urandom_range(16, 63)), $urandom, 4'($urandom_range(0, 15)), 32'h0);
                else
                    dbus_rd(8'($urandom_range(0, 63)));
            end
        join
        for (int a = 16; a < 64; a++) dbus_rd(8'(a));

        repeat (3) @(negedge clk);
        chk("ibq_drained", 32'(ibq.size()), 32'd0);
        chk("dbq_drained", 32'(dbq_we.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servant_ram_arbiter.md
Name: servant_ram_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single-port servant RAM between the CPU instruction bus (read-only) and data bus (read/write).
- Registered round-robin grant; the grant is held for one complete RAM transaction, acknowledged by the RAM's single-cycle ack.
- Sits between the core's ibus/dbus and the RAM slave port.

Parameters:
- aw, 10, RAM byte-address width; word address carried as [aw-1:2]
- IBUS_FIRST, 1, after reset, ibus wins the first simultaneous request (1) or dbus wins it (0)

Ports:
- i_wb_clk  in  1  clock
- i_wb_rst  in  1  reset, asynchronous, active-high
- i_ibus_adr  in  aw-2  ibus word address
- i_ibus_cyc  in  1  ibus request
- o_ibus_rdt  out  32  ibus read data
- o_ibus_ack  out  1  ibus ack
- i_dbus_adr  in  aw-2  dbus word address
- i_dbus_dat  in  32  dbus write data
- i_dbus_sel  in  4  dbus byte enables
- i_dbus_we  in  1  dbus write enable
- i_dbus_cyc  in  1  dbus request
- o_dbus_rdt  out  32  dbus read data
- o_dbus_ack  out  1  dbus ack
- o_ram_adr  out  aw-2  RAM word address
- o_ram_dat  out  32  RAM write data
- o_ram_sel  out  4  RAM byte enables
- o_ram_we  out  1  RAM write enable
- o_ram_cyc  out  1  RAM request
- i_ram_rdt  in  32  RAM read data
- i_ram_ack  in  1  RAM ack (asserted one cycle after cyc; never on two consecutive cycles)

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. One flop last_i records whether ibus was the most recently granted master.
- Async reset: state IDLE; last_i = !IBUS_FIRST. Outputs while in reset: o_ram_cyc=0, o_ram_we=0, o_ibus_ack=0, o_dbus_ack=0.
- Next-grant function:
  - Only one cyc high: that master.
  - Both high: the master not last granted.
  - Neither high: IDLE.
- IDLE: on the clock edge, move to the next grant. last_i updates when the grant is taken.
- GNT_x: held until i_ram_ack=1.
  - In the ack cycle, the next state is re-evaluated with the acked master's cyc masked off.
  - This lets the other master be granted back-to-back; otherwise the FSM returns to IDLE.
- o_ram_cyc = (state != IDLE); this is a registered decode.
- RAM mux:
  - GNT_D: adr/dat/sel/we from dbus.
  - GNT_I: adr from ibus, we=0, sel=4'hF, dat=0.
  - IDLE: adr/dat/sel from dbus, we=0.
- Acks are combinational:
  - o_ibus_ack = i_ram_ack & GNT_I & i_ibus_cyc
  - o_dbus_ack = i_ram_ack & GNT_D & i_dbus_cyc
- o_ibus_rdt = o_dbus_rdt = i_ram_rdt (broadcast). Masters qualify read data with their own ack.
- Latency, request seen in cycle 0:
  - Grant and o_ram_cyc in cycle 1.
  - RAM ack and master ack in cycle 2.
  - The alternate master can be granted in cycle 3 and acked in cycle 4.
- Masters must drop cyc after ack.
- Boundary conditions:
  - Master drops cyc while granted: the grant is still held until RAM ack; that ack is suppressed (not forwarded).
  - i_ram_ack while IDLE: ignored; no state change.
  - Both requesting continuously: strict alternation I,D,I,D; neither master starves.
  - dbus write with sel=0: passed through unchanged and acked normally.
  - Async reset mid-transaction: returns to IDLE immediately. A RAM ack arriving in the first cycle after reset release is ignored, and no master ack is produced.
- No combinational path from any cyc input to o_ram_cyc.

Test Plan:
- Single ibus read: RAM word 0x10 preloaded with 0xDEADBEEF, ibus cyc adr=0x10 at cycle 0 -> o_ram_cyc=1 cycle 1, o_ibus_ack=1 with rdt=0xDEADBEEF cycle 2, o_dbus_ack never asserted.
- dbus byte write then read: write adr=0x4 dat=0x11223344 sel=4'b0010 over initial 0 -> ack cycle 2, o_ram_we=1 only in GNT_D; readback returns 0x00003300.
- Simultaneous requests after reset (IBUS_FIRST=1), both cyc held: grants I,D,I,D, one ack every 2 cycles, acks never coincident; with IBUS_FIRST=0 the first grant is D.
- Back-to-back hand-off: dbus requests during an ibus transaction -> dbus granted in the cycle after ibus ack, with no IDLE cycle.
- Protocol abuse: ibus drops cyc in cycle 1 while granted -> o_ibus_ack stays 0, FSM returns to IDLE after the RAM ack; a spurious i_ram_ack in IDLE causes no ack and no state change.
- Reset in the cycle o_ram_cyc=1 -> o_ram_cyc=0 immediately; no master ack in the following 3 cycles; a subsequent dbus request completes normally.
